// File: rtl/game_fsm.sv
// Game-flow controller: cover -> play -> success/game-over, with life/bomb accounting.
// Optional GAME_FSM_GODMODE_EN: collisions still flash HIT but never cost a life.
module game_fsm #(
  parameter int unsigned INIT_LIFE     = 3,
  parameter int unsigned INIT_BOMB     = 3,
  parameter int unsigned INVULN_CYCLES = 50_000_000,
  parameter int unsigned BOMB_CYCLES   = 50_000_000
) (
  input  logic       clk,
  input  logic       hard_reset,
  input  logic       enter,
  input  logic       bomb,
  input  logic       collision,
  input  logic       die,
  output logic [3:0] num_life,
  output logic [3:0] num_bomb,
  output logic [3:0] game_state,
  output logic       game_en,
  output logic       game_reset
);

  typedef enum logic [3:0] {
    StCover    = 4'b0001,
    StPlay     = 4'b0010,
    StBomb     = 4'b0011,
    StHit      = 4'b0100,
    StSuccess  = 4'b1000,
    StGameover = 4'b1001
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  life_q, life_d;
  logic [3:0]  bombs_q, bombs_d;
  logic [31:0] timer_q, timer_d;
  logic        enter_q, bomb_q;
  logic        reset_q, reset_d;
  logic        enter_rise, bomb_rise;

  assign enter_rise = enter & ~enter_q;
  assign bomb_rise  = bomb & ~bomb_q;

  always_comb begin
    state_d = state_q;
    life_d  = life_q;
    bombs_d = bombs_q;
    timer_d = timer_q;
    reset_d = 1'b0;
    case (state_q)
      StCover: begin
        if (enter_rise) begin
          life_d  = 4'(INIT_LIFE);
          bombs_d = 4'(INIT_BOMB);
          state_d = StPlay;
          reset_d = 1'b1;
        end
      end
      StPlay: begin
        if (die) begin
          state_d = StSuccess;
        end else if (collision) begin
`ifdef GAME_FSM_GODMODE_EN
          state_d = StHit;
          timer_d = '0;
`else
          if (life_q <= 4'd1) begin
            life_d  = 4'd0;
            state_d = StGameover;
          end else begin
            life_d  = life_q - 4'd1;
            state_d = StHit;
            timer_d = '0;
          end
`endif
        end else if (bomb_rise && (bombs_q != 4'd0)) begin
          bombs_d = bombs_q - 4'd1;
          state_d = StBomb;
          timer_d = '0;
        end
      end
      StHit: begin
        timer_d = timer_q + 32'd1;
        if (die) begin
          state_d = StSuccess;
        end else if (timer_q == INVULN_CYCLES - 1) begin
          state_d = StPlay;
        end
      end
      StBomb: begin
        timer_d = timer_q + 32'd1;
        if (die) begin
          state_d = StSuccess;
        end else if (timer_q == BOMB_CYCLES - 1) begin
          state_d = StPlay;
        end
      end
      StSuccess, StGameover: begin
        // Counters stay frozen here; they are reloaded on the next start from cover.
        if (enter_rise) state_d = StCover;
      end
      default: state_d = StCover;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hard_reset) begin
      state_q <= StCover;
      life_q  <= 4'(INIT_LIFE);
      bombs_q <= 4'(INIT_BOMB);
      timer_q <= '0;
      reset_q <= 1'b0;
      // Keys held through reset must not register as a press.
      enter_q <= 1'b1;
      bomb_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      life_q  <= life_d;
      bombs_q <= bombs_d;
      timer_q <= timer_d;
      reset_q <= reset_d;
      enter_q <= enter;
      bomb_q  <= bomb;
    end
  end

  assign num_life   = life_q;
  assign num_bomb   = bombs_q;
  assign game_state = state_q;
  assign game_en    = (state_q == StPlay) || (state_q == StBomb) || (state_q == StHit);
  assign game_reset = reset_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed self-checking bench for game_fsm with short invulnerability/bomb windows.
module tb_game_fsm;

  logic       clk = 1'b0;
  logic       hard_reset, enter, bomb, collision, die;
  logic [3:0] num_life, num_bomb, game_state;
  logic       game_en, game_reset;

  int tests = 0;
  int fails = 0;

  localparam logic [3:0] COVER = 4'b0001, PLAY = 4'b0010, BOMB = 4'b0011,
                         HIT = 4'b0100, SUCCESS = 4'b1000, GAMEOVER = 4'b1001;

  game_fsm #(
    .INIT_LIFE    (3),
    .INIT_BOMB    (3),
    .INVULN_CYCLES(8),
    .BOMB_CYCLES  (4)
  ) dut (
    .clk       (clk),
    .hard_reset(hard_reset),
    .enter     (enter),
    .bomb      (bomb),
    .collision (collision),
    .die       (die),
    .num_life  (num_life),
    .num_bomb  (num_bomb),
    .game_state(game_state),
    .game_en   (game_en),
    .game_reset(game_reset)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic [3:0] life,
                         input logic [3:0] bmb, input logic en, input logic rst);
    chk({tag, ".state"}, {4'd0, game_state}, {4'd0, st});
    chk({tag, ".life"},  {4'd0, num_life},   {4'd0, life});
    chk({tag, ".bomb"},  {4'd0, num_bomb},   {4'd0, bmb});
    chk({tag, ".en"},    {7'd0, game_en},    {7'd0, en});
    chk({tag, ".rst"},   {7'd0, game_reset}, {7'd0, rst});
  endtask

  initial begin
    hard_reset = 1'b1;
    enter      = 1'b1;
    bomb       = 1'b0;
    collision  = 1'b0;
    die        = 1'b0;
    step();
    step();
    chk_all("reset", COVER, 4'd3, 4'd3, 1'b0, 1'b0);

    // Enter held across reset release: no start.
    hard_reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk_all("held_enter", COVER, 4'd3, 4'd3, 1'b0, 1'b0);

    enter = 1'b0;
    step();
    enter = 1'b1;
    step();
    chk_all("start", PLAY, 4'd3, 4'd3, 1'b1, 1'b1);
    enter = 1'b0;
    step();
    chk_all("start_p1", PLAY, 4'd3, 4'd3, 1'b1, 1'b0);

    // Collision held: lose a life, 8 cycles of HIT, then another life.
    collision = 1'b1;
    step();
    chk_all("hit1", HIT, 4'd2, 4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("hit1_hold", {4'd0, game_state}, {4'd0, HIT});
    end
    step();
    chk_all("hit1_end", PLAY, 4'd2, 4'd3, 1'b1, 1'b0);
    step();
    chk_all("hit2", HIT, 4'd1, 4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step();
    step();
    chk_all("hit2_end", PLAY, 4'd1, 4'd3, 1'b1, 1'b0);
    step();
    chk_all("gameover", GAMEOVER, 4'd0, 4'd3, 1'b0, 1'b0);
    collision = 1'b0;
    step();
    chk_all("gameover_hold", GAMEOVER, 4'd0, 4'd3, 1'b0, 1'b0);

    enter = 1'b1;
    step();
    chk_all("to_cover", COVER, 4'd0, 4'd3, 1'b0, 1'b0);
    enter = 1'b0;
    step();
    enter = 1'b1;
    step();
    chk_all("restart", PLAY, 4'd3, 4'd3, 1'b1, 1'b1);
    enter = 1'b0;

    // Three bombs, each a 4-cycle BOMB window; collision inside one is ignored.
    for (int k = 0; k < 3; k++) begin
      bomb = 1'b1;
      step();
      chk_all("bomb_use", BOMB, 4'd3, 4'(2 - k), 1'b1, 1'b0);
      bomb      = 1'b0;
      collision = (k == 0);
      step();
      chk("bomb_hold", {4'd0, game_state}, {4'd0, BOMB});
      collision = 1'b0;
      step();
      step();
      chk("bomb_hold_last", {4'd0, game_state}, {4'd0, BOMB});
      step();
      chk_all("bomb_end", PLAY, 4'd3, 4'(2 - k), 1'b1, 1'b0);
    end
    bomb = 1'b1;
    step();
    chk_all("bomb_empty", PLAY, 4'd3, 4'd0, 1'b1, 1'b0);
    bomb = 1'b0;
    step();

    // die beats collision in the same cycle.
    die       = 1'b1;
    collision = 1'b1;
    step();
    chk_all("success", SUCCESS, 4'd3, 4'd0, 1'b0, 1'b0);
    die       = 1'b0;
    collision = 1'b0;
    step();
    chk_all("success_hold", SUCCESS, 4'd3, 4'd0, 1'b0, 1'b0);

    hard_reset = 1'b1;
    step();
    chk_all("hard_reset", COVER, 4'd3, 4'd3, 1'b0, 1'b0);
    hard_reset = 1'b0;
    step();
    chk_all("post_reset", COVER, 4'd3, 4'd3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
